lc4_fetch: RTL and testbench

LC4_FETCH -- requirements
Module: lc4_fetch

---
 rtl/lc4_fetch.sv | 146 ++++++++++++++
 tb/tb_lc4_fetch.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/lc4_fetch.sv
// LC4 instruction fetch stage.
// Issues sequential instruction-memory reads (fixed 1-cycle read latency),
// buffers returned words in a 2-entry in-order skid FIFO tagged with their PC,
// and presents the FIFO head to decode with a valid/ready handshake.
// A control-flow redirect flushes the FIFO, drops the word returning that
// cycle and immediately fetches from the redirect target.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   imem_req, imem_addr   read request / address to instruction memory
//   imem_rdata            read data for the request issued last cycle
//   redirect_valid/target control-flow redirect and new fetch PC
//   insn_valid/insn_ready handshake to decode
//   insn, insn_pc, insn_pc_plus_one  FIFO head payload
module lc4_fetch (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  output logic        insn_valid,
  input  logic        insn_ready,
  output logic [15:0] insn,
  output logic [15:0] insn_pc,
  output logic [15:0] insn_pc_plus_one
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam logic [AW-1:0] RESET_PC = 16'h8200;

  // FIFO occupancy doubles as the FSM state
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e          state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] req_pc_q, req_pc_d;
  logic          inflight_q;
  logic [DW-1:0] ins0_q, ins0_d, ins1_q, ins1_d;
  logic [AW-1:0] epc0_q, epc0_d, epc1_q, epc1_d;

  logic          pop;
  logic          push;
  logic [2:0]    occ;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      ins0_q     <= '0;
      ins1_q     <= '0;
      epc0_q     <= '0;
      epc1_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= imem_req;
      ins0_q     <= ins0_d;
      ins1_q     <= ins1_d;
      epc0_q     <= epc0_d;
      epc1_q     <= epc1_d;
    end
  end

  // Next-state, request issue and FIFO update
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    ins0_d    = ins0_q;
    ins1_d    = ins1_q;
    epc0_d    = epc0_q;
    epc1_d    = epc1_q;
    imem_req  = 1'b0;
    imem_addr = pc_q;

    pop  = (state_q != EMPTY) & insn_ready;
    push = inflight_q & ~redirect_valid;
    // Occupancy after this cycle's pop, counting the word still in flight;
    // issuing only when it is <= 1 guarantees the FIFO never overflows.
    occ  = 3'(state_q) + 3'(inflight_q) - 3'(pop);

    if (redirect_valid) begin
      // Redirect wins over stall, push and pop: flush and refetch
      imem_req  = rst_n;
      imem_addr = redirect_target;
      pc_d      = redirect_target + 16'd1;
      req_pc_d  = redirect_target;
      state_d   = EMPTY;
    end else begin
      imem_req = rst_n & (occ <= 3'd1);
      if (imem_req) begin
        pc_d     = pc_q + 16'd1;
        req_pc_d = pc_q;
      end

      unique case ({push, pop})
        2'b10: begin
          if (state_q == EMPTY) begin
            ins0_d  = imem_rdata;
            epc0_d  = req_pc_q;
            state_d = ONE;
          end else begin
            ins1_d  = imem_rdata;
            epc1_d  = req_pc_q;
            state_d = FULL;
          end
        end
        2'b01: begin
          ins0_d  = ins1_q;
          epc0_d  = epc1_q;
          state_d = (state_q == FULL) ? ONE : EMPTY;
        end
        2'b11: begin
          // Occupancy unchanged; new word lands behind the surviving entry
          if (state_q == FULL) begin
            ins0_d = ins1_q;
            epc0_d = epc1_q;
            ins1_d = imem_rdata;
            epc1_d = req_pc_q;
          end else begin
            ins0_d = imem_rdata;
            epc0_d = req_pc_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign insn_valid       = (state_q != EMPTY);
  assign insn             = ins0_q;
  assign insn_pc          = epc0_q;
  assign insn_pc_plus_one = epc0_q + 16'd1;

endmodule

// File: tb/tb_lc4_fetch.sv
// Directed testbench for lc4_fetch: memory model returns addr ^ 16'hA5A5.
module tb_lc4_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic        insn_valid;
  logic        insn_ready;
  logic [15:0] insn;
  logic [15:0] insn_pc;
  logic [15:0] insn_pc_plus_one;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [15:0] exp_pc;

  always #5 clk = ~clk;

  // 1-cycle latency instruction memory
  always @(posedge clk) imem_rdata <= imem_addr ^ 16'hA5A5;

  lc4_fetch dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .insn_valid       (insn_valid),
    .insn_ready       (insn_ready),
    .insn             (insn),
    .insn_pc          (insn_pc),
    .insn_pc_plus_one (insn_pc_plus_one)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expect n consecutive in-order deliveries starting at exp_pc (insn_ready=1)
  task automatic stream(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, ".valid"}, 16'(insn_valid), 16'd1);
      chk({tag, ".pc"}, insn_pc, exp_pc);
      chk({tag, ".pc1"}, insn_pc_plus_one, exp_pc + 16'd1);
      chk({tag, ".insn"}, insn, exp_pc ^ 16'hA5A5);
      chk({tag, ".req"}, 16'(imem_req), 16'd1);
      exp_pc = exp_pc + 16'd1;
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    insn_ready = 1'b1;
    step();
    step();
    // Reset values
    chk("rst.valid", 16'(insn_valid), 16'd0);
    chk("rst.req", 16'(imem_req), 16'd0);
    chk("rst.insn", insn, 16'h0000);
    chk("rst.pc", insn_pc, 16'h0000);
    chk("rst.pc1", insn_pc_plus_one, 16'h0001);

    // Reset release: requests 0x8200, 0x8201; first valid two cycles later
    rst_n = 1'b1;
    #1;
    chk("rel.req0", 16'(imem_req), 16'd1);
    chk("rel.addr0", imem_addr, 16'h8200);
    step();
    chk("rel.addr1", imem_addr, 16'h8201);
    chk("rel.valid1", 16'(insn_valid), 16'd0);
    step();
    exp_pc = 16'h8200;
    stream("rel", 4);

    // Stall 4 cycles: FIFO fills, requests stop, head holds
    insn_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("stall.req", 16'(imem_req), 16'd0);
      chk("stall.pc", insn_pc, exp_pc);
      chk("stall.valid", 16'(insn_valid), 16'd1);
      step();
    end
    insn_ready = 1'b1;
    #1;
    stream("unstall", 5);

    // Redirect while FULL and stalled
    insn_ready = 1'b0;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_target = 16'h1234;
    #1;
    chk("rd.req", 16'(imem_req), 16'd1);
    chk("rd.addr", imem_addr, 16'h1234);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("rd.flush", 16'(insn_valid), 16'd0);
    step();
    chk("rd.valid", 16'(insn_valid), 16'd1);
    chk("rd.pc", insn_pc, 16'h1234);
    chk("rd.pc1", insn_pc_plus_one, 16'h1235);
    insn_ready = 1'b1;
    #1;
    exp_pc = 16'h1234;
    stream("rd", 4);

    // PC wrap at 0xFFFF
    redirect_valid = 1'b1;
    redirect_target = 16'hFFFE;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("wrap.flush", 16'(insn_valid), 16'd0);
    step();
    exp_pc = 16'hFFFE;
    stream("wrap", 4);

    // Reset pulse while ONE with a word in flight
    rst_n = 1'b0;
    #1;
    chk("rp.valid", 16'(insn_valid), 16'd0);
    chk("rp.req", 16'(imem_req), 16'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rp.addr", imem_addr, 16'h8200);
    chk("rp.req1", 16'(imem_req), 16'd1);
    step();
    chk("rp.stale", 16'(insn_valid), 16'd0);
    step();
    exp_pc = 16'h8200;
    stream("rp", 3);

    // Back-to-back redirects: only the second target path survives
    redirect_valid = 1'b1;
    redirect_target = 16'h3000;
    step();
    chk("rr.flush1", 16'(insn_valid), 16'd0);
    redirect_target = 16'h4000;
    #1;
    chk("rr.addr", imem_addr, 16'h4000);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("rr.flush2", 16'(insn_valid), 16'd0);
    step();
    exp_pc = 16'h4000;
    stream("rr", 4);

    // A 0x0000 word is delivered like any other
    redirect_valid = 1'b1;
    redirect_target = 16'hA5A5;
    step();
    redirect_valid = 1'b0;
    step();
    chk("nop.valid", 16'(insn_valid), 16'd1);
    chk("nop.insn", insn, 16'h0000);
    chk("nop.pc", insn_pc, 16'hA5A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
